// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD counter / seven-segment display block.
// Segment patterns are active-low, ordered {G,F,E,D,C,B,A}.
package bcd_disp_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Non-BCD nibbles (A..F) saturate to 9 so the counter never holds an illegal digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: loadable, enable-gated up/down digit with a terminal flag
// used by the parent to ripple the enable into the next decade.
module bcd_digit
  import bcd_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] value,
  output logic       term
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 4'd0;
    end else if (load) begin
      value <= bcd_clamp(load_digit);
    end else if (en) begin
      if (up) value <= (value == BCD_MAX) ? 4'd0 : value + 4'd1;
      else    value <= (value == 4'd0) ? BCD_MAX : value - 4'd1;
    end
  end

  assign term = up ? (value == BCD_MAX) : (value == 4'd0);

endmodule

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with tick divider, parallel load, wrap pulse
// and a multiplexed active-low seven-segment driver with leading-zero blanking.
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 5000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   q,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     segcom
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(DIGITS);

  logic [DIV_W-1:0]  div;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  index;
  logic              tick;
  logic [DIGITS-1:0] en;
  logic [DIGITS-1:0] term;
  logic [DIGITS:0]   zero_from;
  logic [3:0]        cur_digit;
  logic              blank;

  assign tick = run && (div == DIV_W'(TICK_DIV - 1));

  // With run low on the terminal count div parks at TICK_DIV-1, so resuming ticks at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (load) begin
      div <= '0;
    end else if (run) begin
      div <= tick ? '0 : div + DIV_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign en[gi] = tick && !load;
      end else begin : g_chain
        assign en[gi] = en[gi-1] && term[gi-1];
      end

      bcd_digit u_digit (
        .clk        (clk),
        .rst_n      (reset),
        .en         (en[gi]),
        .up         (up),
        .load       (load),
        .load_digit (load_value[4*gi +: 4]),
        .value      (q[4*gi +: 4]),
        .term       (term[gi])
      );
    end
  endgenerate

  // The top decade being enabled and terminal means every decade rolls over together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap <= 1'b0;
    else        wrap <= en[DIGITS-1] && term[DIGITS-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      index    <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      index    <= (index == IDX_W'(DIGITS - 1)) ? '0 : index + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // zero_from[i] is set when digits i..DIGITS-1 are all zero.
  always_comb begin
    zero_from[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (q[4*i +: 4] == 4'd0);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_digit = 4'd0;
    blank     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (index == IDX_W'(i)) begin
        cur_digit = q[4*i +: 4];
        blank     = blank_lz && (i != 0) && zero_from[i];
      end
    end
  end

  assign seg    = blank ? SEG_BLANK : bcd_to_seg(cur_digit);
  assign segcom = ~(DIGITS'(1) << index);

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed self-checking bench for bcd_counter_display with DIGITS=4,
// TICK_DIV=4, SCAN_DIV=3; inputs change on falling edges, outputs sampled there.
module tb_bcd_counter_display;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        up;
  logic        load;
  logic [15:0] load_value;
  logic        blank_lz;
  logic [15:0] q;
  logic        wrap;
  logic [6:0]  seg;
  logic [3:0]  segcom;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_counter_display #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .blank_lz   (blank_lz),
    .q          (q),
    .wrap       (wrap),
    .seg        (seg),
    .segcom     (segcom)
  );

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  // Ends on the falling edge where q first shows v.
  task automatic load_val(input logic [15:0] v);
    @(negedge clk);
    load       = 1'b1;
    load_value = v;
    @(negedge clk);
    load       = 1'b0;
  endtask

  // Waits (bounded) for the falling edge at which segcom first becomes target.
  task automatic sync_to(input logic [3:0] target, output bit ok);
    logic [3:0] prev;
    ok   = 1'b0;
    prev = segcom;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (segcom === target && prev !== target) begin
        ok = 1'b1;
        break;
      end
      prev = segcom;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; run = 1'b0; up = 1'b1; load = 1'b0;
    load_value = 16'h0000; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL reset_q: got %h want 0000", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    checks++; if (segcom !== 4'b1110) begin errors++; $display("FAIL reset_segcom: got %b want 1110", segcom); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b want 1000000", seg); end
  endtask

  task automatic test_count_up;
    logic [15:0] exp_q;
    reset = 1'b1; run = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_q = 16'(k / TICK_DIV);
      checks++; if (q !== exp_q) begin errors++; $display("FAIL count_up_q cycle %0d: got %h want %h", k, q, exp_q); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL count_up_wrap cycle %0d: got %b want 0", k, wrap); end
    end
  endtask

  task automatic test_wrap_up;
    run = 1'b1; up = 1'b1;
    load_val(16'h9998);
    checks++; if (q !== 16'h9998) begin errors++; $display("FAIL wrap_up_load: got %h want 9998", q); end
    repeat (4) @(negedge clk);
    checks++; if (q !== 16'h9999) begin errors++; $display("FAIL wrap_up_9999: got %h want 9999", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_early: got %b want 0", wrap); end
    repeat (3) @(negedge clk);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_before: got %b want 0", wrap); end
    @(negedge clk);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL wrap_up_q: got %h want 0000", q); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_up_pulse: got %b want 1", wrap); end
    @(negedge clk);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_one_cycle: got %b want 0", wrap); end
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL wrap_up_hold: got %h want 0000", q); end
  endtask

  task automatic test_wrap_down;
    run = 1'b1; up = 1'b0;
    load_val(16'h0001);
    repeat (4) @(negedge clk);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL down_zero: got %h want 0000", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_zero_wrap: got %b want 0", wrap); end
    repeat (4) @(negedge clk);
    checks++; if (q !== 16'h9999) begin errors++; $display("FAIL down_wrap_q: got %h want 9999", q); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL down_wrap_pulse: got %b want 1", wrap); end
    @(negedge clk);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_one_cycle: got %b want 0", wrap); end
    load_val(16'hA5F3);
    checks++; if (q !== 16'h9593) begin errors++; $display("FAIL load_clamp: got %h want 9593", q); end
  endtask

  task automatic test_load_with_tick;
    run = 1'b1; up = 1'b1;
    load_val(16'h1234);
    repeat (3) @(negedge clk);
    checks++; if (q !== 16'h1234) begin errors++; $display("FAIL load_tick_pre: got %h want 1234", q); end
    load       = 1'b1;
    load_value = 16'h0042;
    @(negedge clk);
    load = 1'b0;
    checks++; if (q !== 16'h0042) begin errors++; $display("FAIL load_tick_q: got %h want 0042", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_tick_wrap: got %b want 0", wrap); end
    repeat (3) @(negedge clk);
    checks++; if (q !== 16'h0042) begin errors++; $display("FAIL load_tick_hold: got %h want 0042", q); end
    @(negedge clk);
    checks++; if (q !== 16'h0043) begin errors++; $display("FAIL load_tick_next: got %h want 0043", q); end
  endtask

  task automatic test_pause;
    run = 1'b1; up = 1'b1;
    load_val(16'h0005);
    repeat (3) @(negedge clk);
    run = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (q !== 16'h0005) begin errors++; $display("FAIL pause_hold: got %h want 0005", q); end
    run = 1'b1;
    @(negedge clk);
    checks++; if (q !== 16'h0006) begin errors++; $display("FAIL pause_resume: got %h want 0006", q); end
    repeat (3) @(negedge clk);
    checks++; if (q !== 16'h0006) begin errors++; $display("FAIL pause_period: got %h want 0006", q); end
    @(negedge clk);
    checks++; if (q !== 16'h0007) begin errors++; $display("FAIL pause_next: got %h want 0007", q); end
  endtask

  task automatic scan_sweep(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] exp_seg [4];
    logic [3:0] one;
    logic [3:0] exp_sc;
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    one = 4'b0001;
    for (int p = 0; p < DIGITS; p++) begin
      exp_sc = ~(one << p);
      for (int c = 0; c < SCAN_DIV; c++) begin
        #1;
        checks++; if (segcom !== exp_sc) begin errors++; $display("FAIL scan_segcom pos %0d cyc %0d: got %b want %b", p, c, segcom, exp_sc); end
        checks++; if (seg !== exp_seg[p]) begin errors++; $display("FAIL scan_seg pos %0d cyc %0d: got %b want %b", p, c, seg, exp_seg[p]); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_scan;
    bit ok;
    run = 1'b0; blank_lz = 1'b1;
    load_val(16'h0070);
    sync_to(4'b1110, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan_sync: got no segcom edge want 1110 within 40 cycles"); end
    scan_sweep(7'b1000000, 7'b1111000, 7'b1111111, 7'b1111111);
    blank_lz = 1'b0;
    scan_sweep(7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000);
  endtask

  task automatic test_async_reset;
    bit ok;
    run = 1'b0; blank_lz = 1'b0;
    load_val(16'h0123);
    sync_to(4'b1011, ok);
    checks++; if (!ok) begin errors++; $display("FAIL areset_sync: got no segcom edge want 1011 within 40 cycles"); end
    checks++; if (q !== 16'h0123) begin errors++; $display("FAIL areset_pre_q: got %h want 0123", q); end
    checks++; if (seg !== 7'b1111001) begin errors++; $display("FAIL areset_pre_seg: got %b want 1111001", seg); end
    #2 reset = 1'b0;
    #1;
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL areset_q: got %h want 0000", q); end
    checks++; if (segcom !== 4'b1110) begin errors++; $display("FAIL areset_segcom: got %b want 1110", segcom); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL areset_seg: got %b want 1000000", seg); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL areset_wrap: got %b want 0", wrap); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_load_with_tick();
    test_pause();
    test_scan();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
